// File: rtl/m8x8_seq_pkg.sv
// Shared state encoding and array geometry constants for the 8x8 tile sequencer.
package m8x8_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        SHIFT,
        DRAIN
    } seq_state_t;

    localparam int ARR_N = 8;
    // The flush clear has to travel the full anti-diagonal to reach mac(7,7).
    localparam int FLUSH_LEN = 2 * ARR_N - 1;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_LEN - 1);

    localparam int CONF_TR   = 0;
    localparam int CONF_RELU = 1;

endpackage

// File: rtl/m8x8_seq_skew_line.sv
// Fixed-depth delay line that only moves when the array advances, so skew and array stall together.
module m8x8_seq_skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DEPTH-1:0][DW-1:0] stage;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage <= '0;
        end else if (adv) begin
            stage[0] <= din;
            for (int s = 1; s < DEPTH; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/m8x8_seq.sv
// Tile sequencer for the 8x8 systolic MAC array: skews operands in, flushes, shifts results out.
// Optional busy/stall performance counters are built when M8X8_SEQ_PERF_EN is defined.
module m8x8_seq
    import m8x8_seq_pkg::*;
#(
    parameter int KW = 16,
    parameter int DW = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic [3:0]                cfg,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ARR_N-1:0][DW-1:0]  in_x,
    input  logic [ARR_N-1:0][DW-1:0]  in_w,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ARR_N-1:0][DW-1:0]  out_data,
    output logic                      out_last,
    output logic [ARR_N-1:0][DW-1:0]  arr_x_in,
    output logic [ARR_N-1:0][DW-1:0]  arr_w_in,
    output logic [ARR_N-1:0][DW-1:0]  arr_y_in,
    output logic [ARR_N-1:0]          arr_clear_in,
    output logic [ARR_N-1:0]          arr_shift,
    output logic                      arr_enable,
    output logic                      arr_reset,
    output logic [3:0]                arr_conf,
    input  logic [ARR_N-1:0][DW-1:0]  arr_z_out
`ifdef M8X8_SEQ_PERF_EN
    ,
    output logic [31:0]               perf_busy,
    output logic [31:0]               perf_stall
`endif
);

    localparam logic [KW-1:0] K_ONE = KW'(1);

    seq_state_t state;
    logic [KW-1:0] k_cnt;
    logic [KW-1:0] k_lat;
    logic [3:0]    flush_cnt;
    logic [2:0]    drain_cnt;
    logic [3:0]    conf_q;
    logic          done_q;
    logic          adv;

    logic [ARR_N-1:0][DW-1:0] src_x;
    logic [ARR_N-1:0][DW-1:0] src_w;
    logic                     src_clr;

    // Everything downstream (skew lines, array, counters) moves on the same advance strobe.
    assign adv = ((state == LOAD) && in_valid) || (state == FLUSH) ||
                 (state == SHIFT) || ((state == DRAIN) && out_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            k_cnt     <= '0;
            k_lat     <= '0;
            flush_cnt <= '0;
            drain_cnt <= '0;
            conf_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_lat     <= k_len;
                        conf_q    <= cfg;
                        k_cnt     <= '0;
                        flush_cnt <= '0;
                        drain_cnt <= '0;
                        state     <= (k_len == '0) ? FLUSH : LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (k_cnt == k_lat - K_ONE) begin
                            k_cnt <= '0;
                            state <= FLUSH;
                        end else begin
                            k_cnt <= k_cnt + K_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        flush_cnt <= '0;
                        state     <= SHIFT;
                    end else begin
                        flush_cnt <= flush_cnt + 4'd1;
                    end
                end
                SHIFT: begin
                    drain_cnt <= '0;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        drain_cnt <= drain_cnt + 3'd1;
                        if (drain_cnt == 3'd7) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operands only enter during LOAD; zeros afterwards drain the skew and keep the flush clean.
    assign src_x   = (state == LOAD) ? in_x : '0;
    assign src_w   = (state == LOAD) ? in_w : '0;
    assign src_clr = ((state == LOAD) && (k_cnt == '0)) ||
                     ((state == FLUSH) && (flush_cnt == 4'd0));

    assign arr_x_in[0]     = src_x[0];
    assign arr_w_in[0]     = src_w[0];
    assign arr_clear_in[0] = src_clr;

    for (genvar i = 1; i < ARR_N; i++) begin : g_skew
        m8x8_seq_skew_line #(.DEPTH(i), .DW(DW)) u_x (
            .clk(clk), .reset(reset), .adv(adv), .din(src_x[i]), .dout(arr_x_in[i])
        );
        m8x8_seq_skew_line #(.DEPTH(i), .DW(DW)) u_w (
            .clk(clk), .reset(reset), .adv(adv), .din(src_w[i]), .dout(arr_w_in[i])
        );
        m8x8_seq_skew_line #(.DEPTH(i), .DW(1)) u_clr (
            .clk(clk), .reset(reset), .adv(adv), .din(src_clr), .dout(arr_clear_in[i])
        );
    end

    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign in_ready   = (state == LOAD);
    assign out_valid  = (state == DRAIN);
    assign out_last   = (state == DRAIN) && (drain_cnt == 3'd7);
    assign out_data   = arr_z_out;
    assign arr_y_in   = '0;
    assign arr_shift  = (state == SHIFT) ? {ARR_N{1'b1}} : '0;
    assign arr_enable = adv;
    assign arr_reset  = ~reset;
    assign arr_conf   = conf_q;

`ifdef M8X8_SEQ_PERF_EN
    // Counters restart with each tile and freeze once it returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if ((state == IDLE) && start) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (busy) begin
            if (perf_busy != '1) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (!adv && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_m8x8_seq.sv
// Bench for m8x8_seq with a behavioural output-stationary 8x8 array model and golden matmul.
module tb_m8x8_seq;

    localparam int KW = 16;
    localparam int DW = 32;
    localparam int N  = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [KW-1:0]         k_len;
    logic [3:0]            cfg;
    logic                  busy;
    logic                  done;
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0][DW-1:0]  in_x;
    logic [N-1:0][DW-1:0]  in_w;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0][DW-1:0]  out_data;
    logic                  out_last;
    logic [N-1:0][DW-1:0]  arr_x_in;
    logic [N-1:0][DW-1:0]  arr_w_in;
    logic [N-1:0][DW-1:0]  arr_y_in;
    logic [N-1:0]          arr_clear_in;
    logic [N-1:0]          arr_shift;
    logic                  arr_enable;
    logic                  arr_reset;
    logic [3:0]            arr_conf;
    logic [N-1:0][DW-1:0]  arr_z_out;
`ifdef M8X8_SEQ_PERF_EN
    logic [31:0]           perf_busy;
    logic [31:0]           perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    m8x8_seq #(.KW(KW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .cfg(cfg),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .arr_x_in(arr_x_in),
        .arr_w_in(arr_w_in), .arr_y_in(arr_y_in), .arr_clear_in(arr_clear_in),
        .arr_shift(arr_shift), .arr_enable(arr_enable), .arr_reset(arr_reset),
        .arr_conf(arr_conf), .arr_z_out(arr_z_out)
`ifdef M8X8_SEQ_PERF_EN
        , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
    );

    // Array model: x and clear flow right along rows, w flows down columns; clear moves acc to standby.
    logic signed [DW-1:0] m_x   [N][N];
    logic signed [DW-1:0] m_w   [N][N];
    logic                 m_clr [N][N];
    logic signed [DW-1:0] m_acc [N][N];
    logic signed [DW-1:0] m_sb  [N][N];
    logic signed [DW-1:0] m_out [N][N];
    logic signed [DW-1:0] op_x  [N][N];
    logic signed [DW-1:0] op_w  [N][N];
    logic signed [DW-1:0] op_p  [N][N];
    logic                 op_c  [N][N];
    logic signed [DW-1:0] nx_out [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                op_x[i][j]   = (j == 0) ? arr_x_in[i] : m_x[i][(j > 0) ? j - 1 : 0];
                op_w[i][j]   = (i == 0) ? arr_w_in[j] : m_w[(i > 0) ? i - 1 : 0][j];
                op_c[i][j]   = (j == 0) ? arr_clear_in[i] : m_clr[i][(j > 0) ? j - 1 : 0];
                op_p[i][j]   = op_x[i][j] * op_w[i][j];
                nx_out[i][j] = arr_shift[i] ? m_sb[i][j] :
                               ((j < N - 1) ? m_out[i][(j < N - 1) ? j + 1 : j] : '0);
            end
            arr_z_out[i] = m_out[i][0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (arr_reset) begin
                    m_x[i][j]   <= '0;
                    m_w[i][j]   <= '0;
                    m_clr[i][j] <= 1'b0;
                    m_acc[i][j] <= '0;
                    m_sb[i][j]  <= '0;
                    m_out[i][j] <= '0;
                end else if (arr_enable) begin
                    m_x[i][j]   <= op_x[i][j];
                    m_w[i][j]   <= op_w[i][j];
                    m_clr[i][j] <= op_c[i][j];
                    m_out[i][j] <= nx_out[i][j];
                    if (op_c[i][j]) begin
                        m_sb[i][j]  <= (arr_conf[1] && m_acc[i][j][DW-1]) ? '0 : m_acc[i][j];
                        m_acc[i][j] <= op_p[i][j];
                    end else begin
                        m_acc[i][j] <= m_acc[i][j] + op_p[i][j];
                    end
                end
            end
        end
    end

    int ta   [N][16];
    int tb   [16][N];
    int gold [N][N];

    typedef struct {
        int         k;
        logic [3:0] cf;
        int         pat;
        bit         stall;
        int         exp_done;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Patterns: 0 A=I,B=j+1; 1 all 2; 2 all 1; 3 random small signed; 4 A=-I,B=I.
    task automatic fillOperands(input int pat, input int kk);
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 16; k++) begin
                case (pat)
                    0: begin ta[i][k] = (i == k) ? 1 : 0;  tb[k][i] = i + 1; end
                    1: begin ta[i][k] = 2;                 tb[k][i] = 2; end
                    2: begin ta[i][k] = 1;                 tb[k][i] = 1; end
                    4: begin ta[i][k] = (i == k) ? -1 : 0; tb[k][i] = (i == k) ? 1 : 0; end
                    default: begin
                        ta[i][k] = int'($urandom_range(15)) - 8;
                        tb[k][i] = int'($urandom_range(15)) - 8;
                    end
                endcase
            end
        end
        if (kk > 16) $fatal(1, "[TB] FAIL operand table too small for k=%0d", kk);
    endtask

    task automatic computeGold(input int kk, input logic relu);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                gold[i][j] = 0;
                for (int k = 0; k < kk; k++) gold[i][j] += ta[i][k] * tb[k][j];
                if (relu && gold[i][j] < 0) gold[i][j] = 0;
            end
        end
    endtask

    task automatic applyStimulus(input int kk, input logic [3:0] cf, input bit stall,
                                 input int exp_done, input string tag);
        int c, ib, ob, stalls, lstalls, shifts, irc;
        bit seen_done;
        logic [N-1:0][DW-1:0] exp_beat;
        c = 0; ib = 0; ob = 0; stalls = 0; lstalls = 0; shifts = 0; irc = 0;
        seen_done = 1'b0;
        computeGold(kk, cf[1]);
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(kk);
        cfg   = cf;
        while (!seen_done && c < 600) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (c == 1) begin
                checkOutput({tag, "_busy"}, 256'(busy), 256'(1));
                checkOutput({tag, "_conf"}, 256'(arr_conf), 256'(cf));
                checkOutput({tag, "_y_in"}, 256'(arr_y_in), 256'(0));
            end
            if (arr_shift != '0) begin
                shifts++;
                checkOutput({tag, "_shift"}, 256'(arr_shift), 256'(8'hFF));
            end
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (out_valid) begin
                    if (ob < N) begin
                        for (int i = 0; i < N; i++) exp_beat[i] = DW'(gold[i][ob]);
                        checkOutput($sformatf("%s_beat%0d", tag, ob), 256'(out_data), 256'(exp_beat));
                        checkOutput($sformatf("%s_last%0d", tag, ob), 256'(out_last), 256'(ob == N - 1));
                    end else begin
                        checkOutput({tag, "_extra_beat"}, 256'(ob), 256'(N - 1));
                    end
                    out_ready = stall ? 1'($urandom_range(1)) : 1'b1;
                    if (out_ready) ob++;
                    else stalls++;
                end else begin
                    out_ready = 1'b1;
                end
                if (in_ready) begin
                    irc++;
                    in_valid = stall ? 1'($urandom_range(1)) : 1'b1;
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            in_x[i] = DW'(ta[i][ib & 15]);
                            in_w[i] = DW'(tb[ib & 15][i]);
                        end
                        ib++;
                    end else begin
                        stalls++;
                        lstalls++;
                    end
                end else begin
                    in_valid = 1'b1;
                    in_x     = {N{32'h5A5A_A5A5}};
                    in_w     = {N{32'h3C3C_C3C3}};
                end
            end
        end
        in_valid = 1'b0;
        checkOutput({tag, "_done_seen"}, 256'(seen_done), 256'(1));
        if (exp_done >= 0) checkOutput({tag, "_done_cycle"}, 256'(c), 256'(exp_done));
        checkOutput({tag, "_beats_in"}, 256'(ib), 256'(kk));
        checkOutput({tag, "_beats_out"}, 256'(ob), 256'(N));
        checkOutput({tag, "_ready_cycles"}, 256'(irc), 256'(kk + lstalls));
        checkOutput({tag, "_shift_count"}, 256'(shifts), 256'(1));
`ifdef M8X8_SEQ_PERF_EN
        checkOutput({tag, "_perf_stall"}, 256'(perf_stall), 256'(stalls));
        checkOutput({tag, "_perf_busy"}, 256'(perf_busy), 256'(kk + 24 + stalls));
`endif
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 256'(done), 256'(0));
        checkOutput({tag, "_idle"}, 256'(busy), 256'(0));
`ifdef M8X8_SEQ_PERF_EN
        checkOutput({tag, "_perf_hold"}, 256'(perf_busy), 256'(kk + 24 + stalls));
`endif
    endtask

    initial begin
        int dcount;
        reset     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        cfg       = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        out_ready = 1'b1;

        vecs[0] = '{k: 8, cf: 4'd0, pat: 0, stall: 1'b0, exp_done: 33};
        vecs[1] = '{k: 3, cf: 4'd0, pat: 1, stall: 1'b0, exp_done: 28};
        vecs[2] = '{k: 1, cf: 4'd0, pat: 2, stall: 1'b0, exp_done: 26};
        vecs[3] = '{k: 5, cf: 4'd0, pat: 3, stall: 1'b1, exp_done: -1};
        vecs[4] = '{k: 0, cf: 4'd0, pat: 1, stall: 1'b0, exp_done: 25};
        vecs[5] = '{k: 8, cf: 4'd2, pat: 4, stall: 1'b0, exp_done: 33};
        vecs[6] = '{k: 5, cf: 4'd2, pat: 3, stall: 1'b1, exp_done: -1};

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_done", 256'(done), 256'(0));
        checkOutput("rst_in_ready", 256'(in_ready), 256'(0));
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_out_last", 256'(out_last), 256'(0));
        checkOutput("rst_enable", 256'(arr_enable), 256'(0));
        checkOutput("rst_shift", 256'(arr_shift), 256'(0));
        checkOutput("rst_clear", 256'(arr_clear_in), 256'(0));
        checkOutput("rst_arr_reset", 256'(arr_reset), 256'(1));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("run_arr_reset", 256'(arr_reset), 256'(0));

        for (int v = 0; v < 7; v++) begin
            fillOperands(vecs[v].pat, vecs[v].k);
            applyStimulus(vecs[v].k, vecs[v].cf, vecs[v].stall, vecs[v].exp_done,
                          $sformatf("vec%0d", v));
        end

        // Reset pulsed while the array is flushing a K=2 tile.
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(2);
        cfg   = 4'd0;
        in_x  = {N{32'd3}};
        in_w  = {N{32'd4}};
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
        end
        checkOutput("mid_busy_flush", 256'(busy), 256'(1));
        checkOutput("mid_no_ready", 256'(in_ready), 256'(0));
        reset = 1'b0;
        #1;
        checkOutput("mid_arr_reset_now", 256'(arr_reset), 256'(1));
        @(negedge clk);
        checkOutput("mid_busy_after", 256'(busy), 256'(0));
        checkOutput("mid_arr_reset", 256'(arr_reset), 256'(1));
        checkOutput("mid_enable", 256'(arr_enable), 256'(0));
        checkOutput("mid_out_valid", 256'(out_valid), 256'(0));
        reset    = 1'b1;
        in_valid = 1'b0;
        dcount   = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checkOutput("mid_no_done", 256'(dcount), 256'(0));

        fillOperands(3, 2);
        applyStimulus(2, 4'd0, 1'b0, 27, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m8x8_seq.md
Name: m8x8_seq

Overview:
- Tile sequencer for the 8x8 systolic MAC array.
- Accepts an unskewed stream of K operand beats (8 x-lanes, 8 w-lanes) and drives the array's port set: w_in, x_in, y_in, clear_in, shift, enable, reset and conf.
  - Skews the operands onto the array.
  - Flushes the accumulators into standby.
  - Shifts the 8x8 result out as 8 output beats.
- Sits between the operand buffers/DMA and the array; one tile in flight at a time.

Parameters:
- KW, 16, width of k_len (max K = 2^KW-1)
- DW, 32, operand/result word width (matches array)
- FLUSH_LEN, 15, flush cycles (2*8-1); fixed by array geometry

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  begin tile; sampled only in IDLE
- k_len  in  KW  inner dimension K, latched on start
- cfg  in  4  array conf (bit0 transpose, bit1 relu), latched on start
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse at tile completion
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when valid&ready
- in_x  in  DW x8  lane i = A[i][k]
- in_w  in  DW x8  lane j = B[k][j]
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream ready
- out_data  out  DW x8  beat j: lane i = C[i][j]
- out_last  out  1  high on beat 7
- arr_x_in  out  DW x8  skewed x to array
- arr_w_in  out  DW x8  skewed w to array
- arr_y_in  out  DW x8  tied 0
- arr_clear_in  out  8  skewed clear
- arr_shift  out  8  shift per row
- arr_enable  out  1  array advance
- arr_reset  out  1  active-high array reset = ~reset
- arr_conf  out  4  latched cfg
- arr_z_out  in  DW x8  array result lanes

Behaviour:
- Reset (reset=0): state IDLE; skew lines, counters and cfg cleared. Outputs busy, done, in_ready, out_valid, out_last, arr_enable, arr_shift, arr_clear_in = 0; arr_reset = 1.
- States:
  - IDLE: start -> LOAD (k_len>0) or FLUSH (k_len=0); start ignored when not IDLE.
  - LOAD: in_ready=1; each handshake is one beat; after beat K-1 accepted -> FLUSH.
  - FLUSH: FLUSH_LEN cycles; in_ready=0; lane sources forced to zero -> SHIFT.
  - SHIFT: one cycle; arr_shift=8'hFF -> DRAIN.
  - DRAIN: 8 beats; out_data = arr_z_out; out_last on beat 7; handshake of beat 7 -> IDLE with done=1 the following cycle.
- Advance: adv = (LOAD&in_valid) | FLUSH | SHIFT | (DRAIN&out_ready). arr_enable = adv. Skew lines and counters move only when adv=1, so the array and skew freeze together.
- Skew:
  - Lane i of x, w and clear is delayed i adv-cycles; lane 0 is combinational.
  - Source mux: in_x/in_w in LOAD, zero otherwise.
  - Clear source = 1 on LOAD beat 0 and FLUSH cycle 0, else 0.
- Timing rationale:
  - Mac(i,j) sees beat k at adv-cycle k+i+j.
  - The flush clear reaches mac(7,7) at F+14, so standby is complete before SHIFT.
  - After SHIFT, arr_z_out[i] = C[i][0]; each DRAIN advance yields the next column.
- Latency (no stalls): start at cycle 0 -> done at cycle K+25.
- Zero-K tile: result beats all 0, since acc holds 0 after reset and after every flush.
- Stalls: in_valid low in LOAD or out_ready low in DRAIN -> arr_enable=0, all state held; out_data stable while out_valid&~out_ready.
- Reset mid-tile: immediate return to IDLE, array reset, no done pulse.
- Arithmetic: format and rounding are those of the shared multiplier/adder; the sequencer does no arithmetic except counters. k_counter wraps never; the compare is against the latched k_len.

Optional Feature:
- Macro: M8X8_SEQ_PERF_EN.
- Defined: adds outputs perf_busy[31:0] (cycles busy=1) and perf_stall[31:0] (busy cycles with adv=0). Both clear on start, saturate at 2^32-1 and hold after done.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package: state enum (IDLE, LOAD, FLUSH, SHIFT, DRAIN), ARR_N=8, FLUSH_LEN, conf bit indices (CONF_TR=0, CONF_RELU=1).
- One sub-module: skew_line (parameter DEPTH, width DW, advance enable), instantiated per lane for x, w and clear (clear with DW=1).

Test Plan:
- A=I, B[k][j]=j+1 (k<8), K=8, no stalls -> out beat j lanes all = j+1; done at cycle 33; out_last on beat 7.
- K=3, all operands 2 -> all 64 results 12; second back-to-back tile with K=1 ones -> all 1 (no residue).
- Random in_valid gaps (50%) and out_ready gaps during drain, K=5 random A,B -> results match golden; data held stable under backpressure.
- k_len=0 start -> no in_ready, 8 beats of zeros, done at cycle 25.
- reset=0 pulsed during FLUSH -> busy=0 and arr_reset=1 next cycle; new K=2 tile gives correct results.
- cfg=2 (relu), A=-I, B=I -> all outputs 0; perf macro on: perf_stall equals injected stall count.
